fp_inv_arb: RTL and testbench
=============================

FP_INV_ARB -- requirements
Module: fp_inv_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one fp_inv instance (legal range 2..8).
REQ-002 The block SHALL have parameter MAX_OUT, default 4, giving the maximum number of in-flight operations per requester (legal range 1..INV_DELAY+1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-006 The block SHALL have port req_x, input, NUM_REQ x FP_BITS: per-requester operand, type fp.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot grant; an operand is accepted when req_valid[i] and req_ready[i] are both high.
REQ-008 The block SHALL have port resp_valid, output, NUM_REQ bits: one-hot result strobe, with no backpressure.
REQ-009 The block SHALL have port resp_inv, output, FP_BITS: 1/x result, type fp, shared by all requesters.
REQ-010 The block SHALL have port idle, output, 1 bit: high when no operation is in flight.

Function
REQ-011 The block SHALL grant at most one requester per cycle, using round-robin order that starts after the last granted index.
REQ-012 Requester i SHALL be eligible for a grant only when req_valid[i] is high and outstanding[i] < MAX_OUT.
REQ-013 req_ready SHALL depend combinationally on req_valid, the round-robin pointer and the outstanding counters, and on no other input.
REQ-014 On acceptance at cycle T, the block SHALL register the operand into an issue stage and present it to fp_inv at T+1.
REQ-015 A tag (valid plus requester ID) SHALL travel through a shift register of depth INV_DELAY+1 alongside the data.
REQ-016 resp_valid[id] SHALL pulse for exactly one cycle at T+1+INV_DELAY (T+9 with default INV_DELAY=8), with resp_inv holding that operation's result.
REQ-017 Sustained issue SHALL reach one operation per cycle; results SHALL return in issue order.
REQ-018 When no result is returning, resp_inv SHALL be FP_ZERO and resp_valid SHALL be 0.
REQ-019 outstanding[i] SHALL increment on accept and decrement on response; on a simultaneous accept and response for the same i, it SHALL be unchanged.
REQ-020 When outstanding[i] == MAX_OUT, req_ready[i] SHALL be 0 and the grant SHALL pass to the next eligible requester in the same cycle.
REQ-021 The round-robin pointer SHALL advance only on an actual grant; it SHALL wrap from NUM_REQ-1 to 0.
REQ-022 idle SHALL be high exactly when every tag stage is invalid and the issue register is empty.

Reset
REQ-023 Asserting rst low SHALL clear, asynchronously, all tag stages, the issue valid bit, all outstanding counters, the pointer (to index 0) and any stats counters.
REQ-024 While rst is low, req_ready, resp_valid and resp_inv SHALL all be 0, and idle SHALL be 1.
REQ-025 Operations in flight when reset asserts SHALL produce no response after reset deasserts; stale data still draining from fp_inv SHALL be masked by invalid tags.
REQ-026 The first grant SHALL be possible in the first clk edge after rst deasserts.

Configuration
REQ-027 With macro FP_INV_ARB_STATS_EN defined, the block SHALL add output stat_issued, NUM_REQ x 32 bits: saturating per-requester accept counts.
REQ-028 With FP_INV_ARB_STATS_EN defined, the block SHALL add output stat_stall, 32 bits: saturating count of cycles with some req_valid high but no grant.
REQ-029 Without FP_INV_ARB_STATS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The fp type, FP_BITS, FP_ZERO and INV_DELAY SHALL come from the shared math package.
REQ-031 The package SHALL gain FP_INV_ARB_ID_BITS ($clog2 of max NUM_REQ = 3) and a packed struct inv_tag_t (valid, id).
REQ-032 The round-robin grant logic SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer internal, advance-on-grant input).
REQ-033 The block SHALL instantiate fp_inv exactly once and SHALL NOT modify it.

Verification
REQ-034 Single request, req 2, x=4.0 at cycle T -> resp_valid=4'b0100 at T+9, resp_inv within 1e-3 relative of 0.25; idle high at T+10.
REQ-035 All four req_valid high for 8 cycles, each with a distinct x -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; results in the same order, each correct for its requester's x.
REQ-036 MAX_OUT=2, only req 1 valid continuously -> grants at T and T+1, req_ready[1]=0 until T+9; re-grant at T+9 because of the simultaneous retire.
REQ-037 Negative operand x=-2.0 -> resp_inv within 1e-3 relative of -0.5 with its sign bit set.
REQ-038 Issue 3 ops, then pull rst low at T+4 for 2 cycles -> no resp_valid ever for those ops; outstanding all 0; next request completes normally at +9.
REQ-039 With FP_INV_ARB_STATS_EN, run REQ-035 stimulus -> stat_issued = 2 for each requester and stat_stall = 0; after holding req 0 at MAX_OUT for 5 cycles, stat_stall = 5.

Source files
------------

// File: rtl/fp_inv_arb_pkg.sv
// Shared math package: fp type, reciprocal latency, and the arbiter's tag definitions.
package fp_inv_arb_pkg;

  localparam int FP_BITS   = 32;
  localparam int INV_DELAY = 8;

  typedef logic [FP_BITS-1:0] fp;

  localparam fp FP_ZERO = '0;

  localparam int FP_INV_ARB_MAX_REQ = 8;
  localparam int FP_INV_ARB_ID_BITS = $clog2(FP_INV_ARB_MAX_REQ);

  typedef struct packed {
    logic                          valid;
    logic [FP_INV_ARB_ID_BITS-1:0] id;
  } inv_tag_t;

  // Truncating single-precision reciprocal; zero/denormal -> signed inf, inf/underflow -> signed zero.
  function automatic fp fp_recip(input fp x);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [22:0] mant;
    int          re;
    fp           r;
    s    = x[31];
    e    = x[30:23];
    m    = x[22:0];
    mant = 23'(48'h8000_0000_0000 / {24'd0, 1'b1, m});
    re   = (m == 23'd0) ? 254 - int'(e) : 253 - int'(e);
    if (e == 8'd0)         r = {s, 8'hFF, 23'd0};
    else if (e == 8'hFF)   r = {s, 31'd0};
    else if (re <= 0)      r = {s, 31'd0};
    else                   r = {s, 8'(re), mant};
    return r;
  endfunction

endpackage

// File: rtl/fp_inv.sv
// fp_inv: reciprocal with a fixed INV_DELAY-cycle pipeline latency, no reset on the datapath.
module fp_inv
  import fp_inv_arb_pkg::*;
(
  input  logic clk,
  input  fp    x,
  output fp    y
);

  fp pipe_d [INV_DELAY];
  fp pipe_q [INV_DELAY];

  always_comb begin
    pipe_d[0] = fp_recip(x);
    for (int i = 1; i < INV_DELAY; i++) pipe_d[i] = pipe_q[i-1];
  end

  // NOTE: pure data stages carry no reset; whoever consumes y qualifies it with its own valid.
  always_ff @(posedge clk) pipe_q <= pipe_d;

  assign y = pipe_q[INV_DELAY-1];

endmodule

// File: rtl/fp_inv_arb_rr.sv
// rr_arbiter: one-hot round-robin grant; the pointer moves past the winner only when advance is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx, win;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
    end
    if (found) gnt[win] = 1'b1;
    ptr_d = ptr_q;
    if (advance && found) ptr_d = (win == PW'(N-1)) ? '0 : win + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp_inv_arb.sv
// fp_inv_arb: round-robin front end sharing one pipelined fp_inv among NUM_REQ requesters.
// Define FP_INV_ARB_STATS_EN to add saturating stat_issued / stat_stall counters.
module fp_inv_arb
  import fp_inv_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  fp    [NUM_REQ-1:0] req_x,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] resp_valid,
  output fp                  resp_inv,
  output logic               idle
`ifdef FP_INV_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] stat_issued,
  output logic [31:0]              stat_stall
`endif
);

  localparam int CW   = $clog2(MAX_OUT + 1);
  localparam int ID_W = FP_INV_ARB_ID_BITS;

  logic [NUM_REQ-1:0] eligible, retire_next;
  logic [CW-1:0]      outst_q [NUM_REQ];
  logic [CW-1:0]      outst_d [NUM_REQ];
  inv_tag_t           tag_q [INV_DELAY+1];
  inv_tag_t           tag_d [INV_DELAY+1];
  fp                  x_q, x_d, inv_y;
  logic               any_acc;
  logic [ID_W-1:0]    acc_id;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = rst && req_valid[i] && (outst_q[i] < CW'(MAX_OUT));
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (eligible),
    .advance (any_acc),
    .gnt     (req_ready)
  );

  always_comb begin
    any_acc = |req_ready;
    acc_id  = '0;
    x_d     = x_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        acc_id = ID_W'(i);
        x_d    = req_x[i];
      end
    end
  end

  // A requester's slot frees the edge before its response cycle, so a full requester is re-granted
  // in the very cycle its oldest result comes back.
  always_comb begin
    tag_d[0].valid = any_acc;
    tag_d[0].id    = acc_id;
    for (int k = 1; k <= INV_DELAY; k++) tag_d[k] = tag_q[k-1];
    retire_next = '0;
    outst_d     = outst_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      retire_next[i] = tag_q[INV_DELAY-1].valid && (tag_q[INV_DELAY-1].id == ID_W'(i));
      outst_d[i]     = outst_q[i] + CW'(req_ready[i]) - CW'(retire_next[i]);
    end
  end

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q   <= '{default: '0};
      outst_q <= '{default: '0};
    end else begin
      tag_q   <= tag_d;
      outst_q <= outst_d;
    end
  end

  always_ff @(posedge clk) x_q <= x_d;

  fp_inv u_inv (
    .clk (clk),
    .x   (x_q),
    .y   (inv_y)
  );

  always_comb begin
    resp_valid = '0;
    resp_inv   = FP_ZERO;
    idle       = 1'b1;
    for (int k = 0; k <= INV_DELAY; k++)
      if (tag_q[k].valid) idle = 1'b0;
    if (tag_q[INV_DELAY].valid) begin
      resp_inv = inv_y;
      for (int i = 0; i < NUM_REQ; i++)
        if (tag_q[INV_DELAY].id == ID_W'(i)) resp_valid[i] = 1'b1;
    end
  end

`ifdef FP_INV_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] issued_q, issued_d;
  logic [31:0]              stall_q, stall_d;

  always_comb begin
    issued_d = issued_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i] && issued_q[i] != 32'hFFFF_FFFF) issued_d[i] = issued_q[i] + 32'd1;
    stall_d = stall_q;
    if (|req_valid && !any_acc && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_fp_inv_arb.sv
// tb_fp_inv_arb: directed steps with a latency-aware scoreboard of expected responses.
module tb_fp_inv_arb;
  import fp_inv_arb_pkg::*;

  localparam int N   = 4;
  localparam int MO  = 2;
  localparam int LAT = INV_DELAY + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  fp    [N-1:0] req_x = '0;
  logic [N-1:0] req_ready, resp_valid;
  fp            resp_inv;
  logic         idle;
`ifdef FP_INV_ARB_STATS_EN
  logic [N-1:0][31:0] stat_issued;
  logic [31:0]        stat_stall;
`endif

  fp_inv_arb #(.NUM_REQ(N), .MAX_OUT(MO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_inv   (resp_inv),
    .idle       (idle)
`ifdef FP_INV_ARB_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int id;
    fp  x;
    int due;
  } exp_t;

  exp_t sb[$];

  // 1.0, 4.0, 3.0, 5.0, 0.75, 10.0, 7.0, 0.1, 1.5, 100.0
  fp xs [10] = '{32'h3F800000, 32'h40800000, 32'h40400000, 32'h40A00000, 32'h3F400000,
                 32'h41200000, 32'h40E00000, 32'h3DCCCCCD, 32'h3FC00000, 32'h42C80000};

  function automatic real fp_to_real(input fp v);
    real m;
    int  e;
    if (v[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(v[22:0]) / 8388608.0;
    e = int'(v[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[31] ? -m : m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rel(input string tag, input fp obs, input real want);
    real got, rel;
    got = fp_to_real(obs);
    rel = (got - want) / want;
    if (rel < 0.0) rel = -rel;
    tests++;
    assert (rel < 1.0e-3) else begin
      fails++;
      $error("FAIL %s: observed %g (%h) expected %g", tag, got, obs, want);
    end
  endtask

  // Scoreboard: record accepts, then match every response against id, cycle and value.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("rst_outputs", {req_ready, resp_valid, resp_inv, idle},
            {4'b0, 4'b0, 32'b0, 1'b1});
    end else begin
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_id", 64'(resp_valid), 64'(1) << e.id);
          check("resp_cycle", 64'(cyc), 64'(e.due));
          check_rel("resp_inv", resp_inv, 1.0 / fp_to_real(e.x));
          check("resp_sign", 64'(resp_inv[31]), 64'(e.x[31]));
        end
      end else begin
        check("resp_zero", 64'(resp_inv), 64'd0);
      end
      check("ready_legal", {$onehot0(req_ready), |(req_ready & ~req_valid)}, 2'b10);
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) sb.push_back('{i, req_x[i], cyc + LAT});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(idle === 1'b1 && sb.size() == 0) && n < 40) begin
      tick();
      n++;
    end
    check(tag, {idle, sb.size() == 0}, 2'b11);
  endtask

  task automatic run_all_four(input int base);
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      req_x[c % 4] = xs[(base + c) % 10];
      #1;
      check("grant_seq", 64'(req_ready), 64'(1) << (c % 4));
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    #2 rst = 1'b0;
    req_valid = '1;
    #10;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_resp", {resp_valid, resp_inv}, 36'd0);

    // Release reset and grant on the very first edge; four requesters in round-robin.
    tick();
    rst = 1'b1;
    run_all_four(0);
`ifdef FP_INV_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stat_issued", 64'(stat_issued[i]), 64'd2);
    check("stat_stall0", 64'(stat_stall), 64'd0);
`endif
    drain("drain_rr");

    // Requester 0 alone: two grants, then blocked at MAX_OUT for five cycles.
    req_valid = 4'b0001;
    req_x[0]  = xs[8];
    for (int k = 0; k < 7; k++) begin
      #1;
      check("full_r0", 64'(req_ready[0]), 64'(k < 2));
      tick();
    end
    req_valid = '0;
    #1;
`ifdef FP_INV_ARB_STATS_EN
    check("stat_stall5", 64'(stat_stall), 64'd5);
`endif
    drain("drain_full0");

    // Requester 1 continuously: re-granted in the cycle its first result retires.
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      req_x[1] = xs[(k % 3) + 1];
      #1;
      check("regrant_r1", 64'(req_ready[1]), 64'(k < 2 || k == 9));
      tick();
    end
    req_valid = '0;
    drain("drain_regrant");

    // Single request on requester 2, x = 4.0.
    req_valid = 4'b0100;
    req_x[2]  = 32'h40800000;
    #1;
    check("single_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 9; k++) begin
      check("single_busy", 64'(idle), 64'd0);
      if (k == 9) begin
        check("single_resp", 64'(resp_valid), 64'h4);
        check_rel("single_inv", resp_inv, 0.25);
      end
      tick();
    end
    check("single_idle", 64'(idle), 64'd1);

    // Negative operand x = -2.0.
    req_valid = 4'b0001;
    req_x[0]  = 32'hC0000000;
    tick();
    req_valid = '0;
    repeat (8) tick();
    check("neg_resp", 64'(resp_valid), 64'h1);
    check("neg_sign", 64'(resp_inv[31]), 64'd1);
    check_rel("neg_inv", resp_inv, -0.5);
    drain("drain_neg");

    // Three ops in flight, then asynchronous reset mid-cycle for two cycles.
    req_valid = 4'b0111;
    req_x[0] = xs[3]; req_x[1] = xs[4]; req_x[2] = xs[5];
    repeat (3) tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0001;
    rst = 1'b0;
    sb.delete();
    #1;
    check("async_ready", 64'(req_ready), 64'd0);
    check("async_idle", 64'(idle), 64'd1);
    tick();
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
`ifdef FP_INV_ARB_STATS_EN
    check("stat_cleared", {stat_issued, stat_stall}, '0);
`endif
    repeat (12) tick();
    check("post_rst_idle", 64'(idle), 64'd1);

    // Counters and pointer cleared: full round-robin again, results after nine cycles.
    run_all_four(3);
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
